mem_wb_pipe: RTL and testbench

- Parametrised successor of the single-lane MEM/WB register.
- Carries LANES independent write-back records (dest reg addr, write enable, data) from the MEM stage to the WB stage.
- Uses a valid/ready handshake backed by a DEPTH-entry FIFO, so MEM can keep issuing while WB back-pressures.
- Supports a synchronous flush, and drives an explicit NOP record on the WB side whenever no valid entry is present.

---
 rtl/mem_wb_pipe.sv | 146 ++++++++++++++
 tb/tb_mem_wb_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// rtl/mem_wb_pipe.sv - multi-lane MEM/WB write-back record buffer with valid/ready handshake
//
// Carries LANES write-back records (dest address, write enable, data) from the
// MEM stage to the WB stage through a DEPTH-entry FIFO. WB sees an all-zero
// NOP record whenever no entry is buffered.
//
// Optional feature macro: MEM_WB_PIPE_STATS_EN (adds stall/bubble counters).
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   flush         synchronous clear of all buffered entries (wins over push/pop)
//   mem_valid     MEM offers a record
//   mem_ready     buffer can accept a record this cycle (registered state only)
//   mem_wd        per-lane dest addresses, lane i at [i*ADDR_W +: ADDR_W]
//   mem_wreg      per-lane write enables
//   mem_wdata     per-lane data, lane i at [i*DATA_W +: DATA_W]
//   wb_valid      head record valid
//   wb_ready      WB consumes the head record this cycle
//   wb_wd         head addresses, 0 when wb_valid=0
//   wb_wreg       head write enables, 0 when wb_valid=0
//   wb_wdata      head data, 0 when wb_valid=0
//   occupancy     entries currently held
//   stall_cycles  (MEM_WB_PIPE_STATS_EN) cycles with mem_valid=1 and mem_ready=0
//   bubble_cycles (MEM_WB_PIPE_STATS_EN) cycles with wb_valid=0 and wb_ready=1

module mem_wb_pipe #(
  parameter int LANES  = 1,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [LANES*ADDR_W-1:0]      mem_wd,
  input  logic [LANES-1:0]             mem_wreg,
  input  logic [LANES*DATA_W-1:0]      mem_wdata,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [LANES*ADDR_W-1:0]      wb_wd,
  output logic [LANES-1:0]             wb_wreg,
  output logic [LANES*DATA_W-1:0]      wb_wdata,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef MEM_WB_PIPE_STATS_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  bubble_cycles
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WD_W  = LANES * ADDR_W;
  localparam int WE_W  = LANES;
  localparam int DAT_W = LANES * DATA_W;
  localparam int REC_W = WD_W + WE_W + DAT_W;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Record storage is deliberately not reset: contents are only observed
  // through count, which is cleared by reset and flush.
  logic [REC_W-1:0] store [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic             push;
  logic             pop;
  logic [REC_W-1:0] head;
  logic [WD_W-1:0]  head_wd;
  logic [WE_W-1:0]  head_wreg;
  logic [DAT_W-1:0] head_wdata;

  // Both handshake flags depend only on count, so there is no combinational
  // path from wb_ready to mem_ready. The cost is that a full buffer cannot
  // accept in the same cycle it drains.
  assign mem_ready = (count != FULL_CNT);
  assign wb_valid  = (count != '0);

  assign push = mem_valid & mem_ready & ~flush;
  assign pop  = wb_valid  & wb_ready  & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally at PTR_W bits.
  always_ff @(posedge clk) begin
    if (push) begin
      store[wr_ptr] <= {mem_wd, mem_wreg, mem_wdata};
    end
  end

  assign head = store[rd_ptr];
  assign {head_wd, head_wreg, head_wdata} = head;

  // Gate to a NOP record so WB never acts on stale storage.
  assign wb_wd     = wb_valid ? head_wd    : '0;
  assign wb_wreg   = wb_valid ? head_wreg  : '0;
  assign wb_wdata  = wb_valid ? head_wdata : '0;
  assign occupancy = count;

`ifdef MEM_WB_PIPE_STATS_EN
  // Counters observe raw handshake levels and ignore flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
    end else begin
      if (mem_valid && !mem_ready) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (!wb_valid && wb_ready) begin
        bubble_cycles <= bubble_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb/tb_mem_wb_pipe.sv - scoreboard bench for mem_wb_pipe with randomized traffic
module tb_mem_wb_pipe;

  localparam int LANES  = 2;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [LANES*ADDR_W-1:0] wd;
    logic [LANES-1:0]        wreg;
    logic [LANES*DATA_W-1:0] wdata;
  } rec_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    flush = 1'b0;
  logic                    mem_valid = 1'b0;
  logic                    mem_ready;
  logic [LANES*ADDR_W-1:0] mem_wd = '0;
  logic [LANES-1:0]        mem_wreg = '0;
  logic [LANES*DATA_W-1:0] mem_wdata = '0;
  logic                    wb_valid;
  logic                    wb_ready = 1'b0;
  logic [LANES*ADDR_W-1:0] wb_wd;
  logic [LANES-1:0]        wb_wreg;
  logic [LANES*DATA_W-1:0] wb_wdata;
  logic [CNT_W-1:0]        occupancy;
`ifdef MEM_WB_PIPE_STATS_EN
  logic [31:0]             stall_cycles;
  logic [31:0]             bubble_cycles;
`endif

  mem_wb_pipe #(
    .LANES (LANES),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_wd   (mem_wd),
    .mem_wreg (mem_wreg),
    .mem_wdata(mem_wdata),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_wd    (wb_wd),
    .wb_wreg  (wb_wreg),
    .wb_wdata (wb_wdata),
    .occupancy(occupancy)
`ifdef MEM_WB_PIPE_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .bubble_cycles(bubble_cycles)
`endif
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  rec_t sb[$];
  bit   mon_en = 1'b0;
  bit   room_q = 1'b1;
  bit   acc = 1'b0;
  rec_t cur_rec = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    r.wd    = LANES*ADDR_W'($urandom);
    r.wreg  = LANES'($urandom);
    r.wdata = {$urandom, $urandom};
    return r;
  endfunction

  // Monitor: the model is the queue itself, bounded at DEPTH entries.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("occupancy", 128'(occupancy), 128'(sb.size()));
      chk("mem_ready", 128'(mem_ready), 128'(sb.size() < DEPTH));
      chk("wb_valid", 128'(wb_valid), 128'(sb.size() != 0));
      if (sb.size() != 0) begin
        chk("wb_wd", 128'(wb_wd), 128'(sb[0].wd));
        chk("wb_wreg", 128'(wb_wreg), 128'(sb[0].wreg));
        chk("wb_wdata", 128'(wb_wdata), 128'(sb[0].wdata));
      end else begin
        chk("nop_wd", 128'(wb_wd), 128'd0);
        chk("nop_wreg", 128'(wb_wreg), 128'd0);
        chk("nop_wdata", 128'(wb_wdata), 128'd0);
      end
      room_q = (sb.size() < DEPTH);
      if (flush) begin
        sb.delete();
      end else if (wb_valid && wb_ready && sb.size() != 0) begin
        void'(sb.pop_front());
      end
    end
  end

  // Wait for the next edge and log the record MEM offered in the cycle before it.
  task automatic advance();
    @(posedge clk);
    #1;
    acc = mem_valid && !flush && room_q;
    if (acc) sb.push_back(cur_rec);
  endtask

  task automatic drive(input logic v, input rec_t r, input logic wr, input logic fl);
    mem_valid = v;
    cur_rec   = r;
    mem_wd    = r.wd;
    mem_wreg  = r.wreg;
    mem_wdata = r.wdata;
    wb_ready  = wr;
    flush     = fl;
  endtask

  task automatic step(input logic v, input rec_t r, input logic wr, input logic fl);
    advance();
    drive(v, r, wr, fl);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_wb_valid"}, 128'(wb_valid), 128'd0);
    chk({tag, "_wb_wd"}, 128'(wb_wd), 128'd0);
    chk({tag, "_wb_wreg"}, 128'(wb_wreg), 128'd0);
    chk({tag, "_wb_wdata"}, 128'(wb_wdata), 128'd0);
    chk({tag, "_occupancy"}, 128'(occupancy), 128'd0);
    chk({tag, "_mem_ready"}, 128'(mem_ready), 128'd1);
  endtask

  // Asserts reset between clock edges and checks the asynchronous clear.
  task automatic async_reset();
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    sb.delete();
    room_q = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    mon_en = 1'b1;
  endtask

  rec_t r1, r2, r3, rt;
  int   n;
`ifdef MEM_WB_PIPE_STATS_EN
  logic [31:0] snap;
`endif

  initial begin
    #2;
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;

    // Single two-lane record, then NOP on the following cycle.
    rt.wd    = {5'd7, 5'd3};
    rt.wreg  = 2'b01;
    rt.wdata = {32'h0000_0005, 32'hAAAA_0001};
    step(1'b1, rt, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("single_wb_valid", 128'(wb_valid), 128'd1);
    chk("single_wb_wdata", 128'(wb_wdata), 128'(rt.wdata));
    step(1'b0, '0, 1'b1, 1'b0);
    chk("single_nop_valid", 128'(wb_valid), 128'd0);

    // Back-pressure: fill, stall the third record, drain in order.
    r1 = rand_rec(); r2 = rand_rec(); r3 = rand_rec();
    step(1'b1, r1, 1'b0, 1'b0);
    step(1'b1, r2, 1'b0, 1'b0);
    step(1'b1, r3, 1'b0, 1'b0);
    chk("full_occupancy", 128'(occupancy), 128'd2);
    chk("full_mem_ready", 128'(mem_ready), 128'd0);
    step(1'b1, r3, 1'b0, 1'b0);
    drive(1'b1, r3, 1'b1, 1'b0);
    n = 0;
    do begin
      advance();
      n++;
    end while (!acc && n < 10);
    chk("r3_accepted", 128'(acc), 128'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);

    // Streaming at full rate with pointer wrap.
    for (int i = 0; i < 20; i++) begin
      rt = rand_rec();
      rt.wdata[DATA_W-1:0] = 32'(i);
      step(1'b1, rt, 1'b1, 1'b0);
      if (i >= 2) chk("stream_occupancy", 128'(occupancy), 128'd1);
    end
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);

    // Flush with a simultaneous offer: everything discarded.
    step(1'b1, rand_rec(), 1'b0, 1'b0);
    step(1'b1, rand_rec(), 1'b0, 1'b0);
    step(1'b1, rand_rec(), 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("flush_occupancy", 128'(occupancy), 128'd0);
    chk("flush_wb_valid", 128'(wb_valid), 128'd0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);

    // Reset mid-stream while holding two entries.
    step(1'b1, rand_rec(), 1'b0, 1'b0);
    step(1'b1, rand_rec(), 1'b0, 1'b0);
    step(1'b1, rand_rec(), 1'b0, 1'b0);
    chk("pre_rst_occupancy", 128'(occupancy), 128'd2);
    async_reset();
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);

`ifdef MEM_WB_PIPE_STATS_EN
    step(1'b1, rand_rec(), 1'b0, 1'b0);
    step(1'b1, rand_rec(), 1'b0, 1'b0);
    step(1'b1, rand_rec(), 1'b0, 1'b0);
    snap = stall_cycles;
    repeat (4) step(1'b1, rand_rec(), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("stall_cycles", 128'(stall_cycles - snap), 128'd5);
    async_reset();
    step(1'b0, '0, 1'b1, 1'b0);
    snap = bubble_cycles;
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("bubble_cycles", 128'(bubble_cycles - snap), 128'd3);
`endif

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_rec(), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 23) == 0));
    end
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
